// File: rtl/mips_pkg.sv
// Shared MIPS pipeline types: EX/MEM and MEM/WB bundles,
// write-back select codes, peripheral map and timer control bits.
package mips_pkg;

  localparam int EXM_W = 140;
  localparam int MWB_W = 38;

  typedef struct packed {
    logic        br_taken;
    logic        lu_op;
    logic [31:0] lu_data;
    logic [31:0] pc_plus4;
    logic [1:0]  mem_to_reg;
    logic        reg_write;
    logic        mem_write;
    logic        mem_read;
    logic [4:0]  write_reg;
    logic [31:0] alu;
    logic [31:0] st_data;
  } ex_mem_t;

  typedef struct packed {
    logic        reg_write;
    logic [4:0]  write_reg;
    logic [31:0] wdata;
  } mem_wb_t;

  localparam logic [1:0] MTR_ALU = 2'b00;
  localparam logic [1:0] MTR_MEM = 2'b01;
  localparam logic [1:0] MTR_PC4 = 2'b10;

  localparam logic [31:0] PERIPH_TH   = 32'h4000_0000;
  localparam logic [31:0] PERIPH_TL   = 32'h4000_0004;
  localparam logic [31:0] PERIPH_TCON = 32'h4000_0008;
  localparam logic [31:0] PERIPH_LED  = 32'h4000_000C;
  localparam logic [31:0] PERIPH_SW   = 32'h4000_0010;

  localparam int TCON_EN = 0;
  localparam int TCON_IE = 1;
  localparam int TCON_ST = 2;

  localparam logic [1:0] TSEL_TH   = 2'd0;
  localparam logic [1:0] TSEL_TL   = 2'd1;
  localparam logic [1:0] TSEL_TCON = 2'd2;

endpackage

// File: rtl/timer_periph.sv
// Reloading 32-bit up-counter with sticky interrupt status.
// Software stores take priority over the counter's own update.
module timer_periph
  import mips_pkg::*;
(
  input  logic        clk,
  input  logic        reset_b,
  input  logic        wr_en,
  input  logic [1:0]  wr_sel,
  input  logic [31:0] wr_data,
  output logic [31:0] th,
  output logic [31:0] tl,
  output logic [2:0]  tcon,
  output logic        irq
);

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      th   <= '0;
      tl   <= '0;
      tcon <= '0;
    end else begin
      if (tcon[TCON_EN]) begin
        if (tl == 32'hFFFF_FFFF) begin
          tl <= th;
          if (tcon[TCON_IE])
            tcon[TCON_ST] <= 1'b1;
        end else begin
          tl <= tl + 32'd1;
        end
      end
      // later assignment overrides the counter update
      if (wr_en) begin
        case (wr_sel)
          TSEL_TH:   th   <= wr_data;
          TSEL_TL:   tl   <= wr_data;
          TSEL_TCON: tcon <= wr_data[2:0];
          default:   ;
        endcase
      end
    end
  end

  assign irq = tcon[TCON_IE] & tcon[TCON_ST];

endmodule

// File: rtl/mem_stage.sv
// MEM stage: data RAM, memory-mapped timer/LED/switch,
// write-back select and the MEM/WB register.
module mem_stage
  import mips_pkg::*;
#(
  parameter int RAM_WORDS = 256,
  parameter int RAM_AW    = 8
) (
  input  logic             clk,
  input  logic             reset_b,
  input  logic [EXM_W-1:0] EX_MEM,
  input  logic [7:0]       switch,
  output logic [4:0]       EX_MEM_Rd,
  output logic             EX_MEM_RegWrite,
  output logic [31:0]      EX_MEM_RdData,
  output logic [4:0]       MEM_WB_Rd,
  output logic             MEM_WB_RegWrite,
  output logic [31:0]      MEM_WB_RdData,
  output logic [MWB_W-1:0] MEM_WB,
  output logic [7:0]       led,
  output logic             irq
);

  ex_mem_t ex;
  assign ex = ex_mem_t'(EX_MEM);

  logic [31:0] addr;
  assign addr = ex.alu;

  logic ram_hit, th_hit, tl_hit;
  logic tcon_hit, led_hit, sw_hit;
  logic [RAM_AW-1:0] ram_idx;

  assign ram_hit  = (addr >> (RAM_AW + 2)) == 32'd0;
  assign ram_idx  = addr[RAM_AW+1:2];
  assign th_hit   = addr[31:2] == PERIPH_TH[31:2];
  assign tl_hit   = addr[31:2] == PERIPH_TL[31:2];
  assign tcon_hit = addr[31:2] == PERIPH_TCON[31:2];
  assign led_hit  = addr[31:2] == PERIPH_LED[31:2];
  assign sw_hit   = addr[31:2] == PERIPH_SW[31:2];

  logic unused_bits;
  assign unused_bits = ^{ex.br_taken, ex.mem_read, addr[1:0]};

  logic [31:0] th, tl;
  logic [2:0]  tcon;
  logic        tmr_we;
  logic [1:0]  tmr_sel;

  assign tmr_we  = ex.mem_write & (th_hit | tl_hit | tcon_hit);
  assign tmr_sel = tl_hit   ? TSEL_TL   :
                   tcon_hit ? TSEL_TCON : TSEL_TH;

  timer_periph u_timer (
    .clk     (clk),
    .reset_b (reset_b),
    .wr_en   (tmr_we),
    .wr_sel  (tmr_sel),
    .wr_data (ex.st_data),
    .th      (th),
    .tl      (tl),
    .tcon    (tcon),
    .irq     (irq)
  );

  logic [31:0] ram [RAM_WORDS];
  logic [31:0] ld_data;

  always_comb begin
    ld_data = '0;
    unique case (1'b1)
      ram_hit:  ld_data = ram[ram_idx];
      th_hit:   ld_data = th;
      tl_hit:   ld_data = tl;
      tcon_hit: ld_data = {29'd0, tcon};
      led_hit:  ld_data = {24'd0, led};
      sw_hit:   ld_data = {24'd0, switch};
      default:  ld_data = '0;
    endcase
  end

  logic [31:0] wb_data;

  always_comb begin
    wb_data = ex.alu;
    if (ex.lu_op) begin
      wb_data = ex.lu_data;
    end else begin
      case (ex.mem_to_reg)
        MTR_MEM: wb_data = ld_data;
        MTR_PC4: wb_data = ex.pc_plus4;
        default: wb_data = ex.alu;
      endcase
    end
  end

  // RAM is not cleared; its write is simply held off in reset
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      led    <= '0;
      MEM_WB <= '0;
    end else begin
      if (ex.mem_write && ram_hit)
        ram[ram_idx] <= ex.st_data;
      if (ex.mem_write && led_hit)
        led <= ex.st_data[7:0];
      MEM_WB <= {ex.reg_write, ex.write_reg, wb_data};
    end
  end

  assign EX_MEM_Rd       = ex.write_reg;
  assign EX_MEM_RegWrite = ex.reg_write;
  assign EX_MEM_RdData   = wb_data;

  mem_wb_t wb_q;
  assign wb_q            = mem_wb_t'(MEM_WB);
  assign MEM_WB_Rd       = wb_q.write_reg;
  assign MEM_WB_RegWrite = wb_q.reg_write;
  assign MEM_WB_RdData   = wb_q.wdata;

endmodule
